// File: rtl/cmp_pkg.sv
// Shared types and elaboration-time helpers for the sequential magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/digit_cmp.sv
// Combinational compare of one DIGIT-bit slice of the two operands.
module digit_cmp #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             d_eq,
  output logic             d_gt
);

  assign d_eq = (x == y);
  assign d_gt = (x > y);

endmodule

// File: rtl/seq_mag_compare.sv
// Sequential MSB-first magnitude comparator, DIGIT bits per clock, with signed
// mode, optional early exit and cascade inputs from a lower-order stage.
module seq_mag_compare
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DIGIT      = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             eq_in,
  input  logic             gt_in,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [1:0]       dbg_state
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int IW   = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);
  localparam logic [IW-1:0]    IDX_TOP  = IW'(NDIG - 1);
  localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_width
    $error("seq_mag_compare: WIDTH must be a multiple of DIGIT");
  end

  // Handshake: start is only sampled in IDLE; busy covers RUN and DONE, and
  // done pulses for exactly one cycle when eq/gt/lt become valid.

  cmp_state_t       state;
  cmp_state_t       state_next;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             eq_in_q;
  logic             gt_in_q;
  logic             found;
  logic             found_gt;
  logic             eq_r;
  logic             gt_r;
  logic             lt_r;

  logic [DIGIT-1:0] a_dig [NDIG];
  logic [DIGIT-1:0] b_dig [NDIG];
  logic [DIGIT-1:0] a_sel;
  logic [DIGIT-1:0] b_sel;
  logic             d_eq;
  logic             d_gt;
  logic             hit;
  logic             hit_gt;
  logic             last;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    assign a_dig[g] = a_q[g*DIGIT +: DIGIT];
    assign b_dig[g] = b_q[g*DIGIT +: DIGIT];
  end

  assign a_sel = a_dig[idx];
  assign b_sel = b_dig[idx];

  digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .x    (a_sel),
    .y    (b_sel),
    .d_eq (d_eq),
    .d_gt (d_gt)
  );

  // The first differing digit decides; a later mismatch never overrides it.
  assign hit    = found | ~d_eq;
  assign hit_gt = found ? found_gt : d_gt;
  assign last   = (idx == '0) || ((EARLY_EXIT != 0) && hit);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= IDX_TOP;
      a_q      <= '0;
      b_q      <= '0;
      eq_in_q  <= 1'b0;
      gt_in_q  <= 1'b0;
      found    <= 1'b0;
      found_gt <= 1'b0;
      eq_r     <= 1'b0;
      gt_r     <= 1'b0;
      lt_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Flipping the sign bit maps two's complement onto offset binary.
            a_q      <= signed_mode ? (a ^ SIGN_BIT) : a;
            b_q      <= signed_mode ? (b ^ SIGN_BIT) : b;
            eq_in_q  <= eq_in;
            gt_in_q  <= gt_in;
            idx      <= IDX_TOP;
            found    <= 1'b0;
            found_gt <= 1'b0;
          end
        end
        RUN: begin
          if (!found && !d_eq) begin
            found    <= 1'b1;
            found_gt <= d_gt;
          end
          if (last) begin
            if (hit) begin
              eq_r <= 1'b0;
              gt_r <= hit_gt;
              lt_r <= ~hit_gt;
            end else begin
              eq_r <= eq_in_q;
              gt_r <= gt_in_q & ~eq_in_q;
              lt_r <= ~eq_in_q & ~gt_in_q;
            end
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign eq        = eq_r;
  assign gt        = gt_r;
  assign lt        = lt_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_seq_mag_compare.sv
// Directed bench for seq_mag_compare: three configurations, latency, busy,
// result and control-path checks against hand-computed expectations.
module tb_seq_mag_compare;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        signed_mode;
  logic        eq_in;
  logic        gt_in;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        start_ee;
  logic        start_ct;
  logic        start_w;

  logic busy_ee, done_ee, eq_ee, gt_ee, lt_ee;
  logic busy_ct, done_ct, eq_ct, gt_ct, lt_ct;
  logic busy_w,  done_w,  eq_w,  gt_w,  lt_w;
  logic [1:0] st_ee, st_ct, st_w;

  int checks   = 0;
  int failures = 0;
  int sel      = 0;

  logic cur_busy, cur_done, cur_eq, cur_gt, cur_lt;

  seq_mag_compare #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) u_ee (
    .clk(clk), .rst(rst), .start(start_ee), .a(a8), .b(b8),
    .signed_mode(signed_mode), .eq_in(eq_in), .gt_in(gt_in),
    .busy(busy_ee), .done(done_ee), .eq(eq_ee), .gt(gt_ee), .lt(lt_ee),
    .dbg_state(st_ee)
  );

  seq_mag_compare #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) u_ct (
    .clk(clk), .rst(rst), .start(start_ct), .a(a8), .b(b8),
    .signed_mode(signed_mode), .eq_in(eq_in), .gt_in(gt_in),
    .busy(busy_ct), .done(done_ct), .eq(eq_ct), .gt(gt_ct), .lt(lt_ct),
    .dbg_state(st_ct)
  );

  seq_mag_compare #(.WIDTH(32), .DIGIT(4), .EARLY_EXIT(1)) u_w (
    .clk(clk), .rst(rst), .start(start_w), .a(a32), .b(b32),
    .signed_mode(signed_mode), .eq_in(eq_in), .gt_in(gt_in),
    .busy(busy_w), .done(done_w), .eq(eq_w), .gt(gt_w), .lt(lt_w),
    .dbg_state(st_w)
  );

  always_comb begin
    cur_busy = busy_w;
    cur_done = done_w;
    cur_eq   = eq_w;
    cur_gt   = gt_w;
    cur_lt   = lt_w;
    case (sel)
      0: begin
        cur_busy = busy_ee; cur_done = done_ee;
        cur_eq = eq_ee; cur_gt = gt_ee; cur_lt = lt_ee;
      end
      1: begin
        cur_busy = busy_ct; cur_done = done_ct;
        cur_eq = eq_ct; cur_gt = gt_ct; cur_lt = lt_ct;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    case (s)
      0:       start_ee = v;
      1:       start_ct = v;
      default: start_w  = v;
    endcase
  endtask

  // Start one operation, wait (bounded) for done, then check latency, busy
  // span, results, the single-cycle done pulse and result hold in IDLE.
  // glitch > 0 pulses start with different operands in that RUN cycle.
  task automatic run_op(input int s, input string tag,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic sm, input logic ei, input logic gi,
                        input int exp_lat,
                        input logic xe, input logic xg, input logic xl,
                        input int glitch);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    sel         = s;
    a8          = av[7:0];
    b8          = bv[7:0];
    a32         = av;
    b32         = bv;
    signed_mode = sm;
    eq_in       = ei;
    gt_in       = gi;
    set_start(s, 1'b1);
    @(posedge clk);
    #1 set_start(s, 1'b0);
    cyc      = 0;
    busy_cnt = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == glitch) begin
        a8 = 8'hFF; b8 = 8'h00; a32 = '1; b32 = '0; signed_mode = 1'b0;
        set_start(s, 1'b1);
      end else begin
        set_start(s, 1'b0);
      end
      if (cur_busy === 1'b1) busy_cnt++;
      if (cur_done === 1'b1) break;
    end
    set_start(s, 1'b0);
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_busy_span"}, busy_cnt, exp_lat);
    check({tag, "_eq"}, cur_eq, xe);
    check({tag, "_gt"}, cur_gt, xg);
    check({tag, "_lt"}, cur_lt, xl);
    @(negedge clk);
    check({tag, "_done_pulse"}, cur_done, 1'b0);
    check({tag, "_busy_fall"}, cur_busy, 1'b0);
    check({tag, "_hold"}, {cur_eq, cur_gt, cur_lt}, {xe, xg, xl});
  endtask

  initial begin
    int dn;
    rst = 1'b1;
    start_ee = 1'b0; start_ct = 1'b0; start_w = 1'b0;
    a8 = '0; b8 = '0; a32 = '0; b32 = '0;
    signed_mode = 1'b0; eq_in = 1'b0; gt_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_ee, 1'b0);
    check("rst_done", done_ee, 1'b0);
    check("rst_res", {eq_ee, gt_ee, lt_ee}, 3'b000);
    check("rst_state", st_ee, 2'd0);
    check("rst_busy_ct", busy_ct, 1'b0);
    check("rst_busy_w", busy_w, 1'b0);
    rst = 1'b0;

    run_op(0, "zero_eq",  32'h00, 32'h00, 0, 1, 0, 5, 1, 0, 0, 0);
    run_op(0, "top_lt",   32'h00, 32'h80, 0, 0, 0, 2, 0, 0, 1, 0);
    run_op(1, "ct_gt",    32'h80, 32'h00, 0, 0, 0, 5, 0, 1, 0, 0);
    run_op(1, "ct_lsd",   32'h81, 32'h80, 0, 0, 0, 5, 0, 1, 0, 0);
    run_op(1, "ct_first", 32'hC0, 32'h7F, 0, 0, 0, 5, 0, 1, 0, 0);
    run_op(0, "sgn_lt",   32'hFF, 32'h01, 1, 0, 0, 2, 0, 0, 1, 0);
    run_op(0, "uns_gt",   32'hFF, 32'h01, 0, 0, 0, 2, 0, 1, 0, 0);
    run_op(0, "sgn_min",  32'h80, 32'h7F, 1, 0, 0, 2, 0, 0, 1, 0);
    run_op(0, "mid_lt",   32'h24, 32'h28, 0, 0, 0, 4, 0, 0, 1, 0);
    run_op(0, "casc_gt",  32'h5A, 32'h5A, 0, 0, 1, 5, 0, 1, 0, 0);
    run_op(0, "casc_lt",  32'h5A, 32'h5A, 0, 0, 0, 5, 0, 0, 1, 0);
    run_op(0, "casc_eq",  32'h5A, 32'h5A, 0, 1, 1, 5, 1, 0, 0, 0);
    run_op(1, "ignore",   32'h10, 32'h20, 0, 0, 0, 5, 0, 0, 1, 2);
    run_op(2, "wide",     32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 0, 0, 9, 0, 0, 1, 0);

    // Reset in the second RUN cycle abandons the operation.
    @(negedge clk);
    sel = 0; a8 = 8'h33; b8 = 8'h33; signed_mode = 1'b0; eq_in = 1'b0; gt_in = 1'b1;
    start_ee = 1'b1;
    @(posedge clk);
    #1 start_ee = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy_ee, 1'b0);
    check("mid_rst_done", done_ee, 1'b0);
    check("mid_rst_res", {eq_ee, gt_ee, lt_ee}, 3'b000);
    check("mid_rst_state", st_ee, 2'd0);
    rst = 1'b0;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_ee === 1'b1) dn++;
    end
    check("mid_rst_no_done", dn, 0);

    run_op(0, "post_rst", 32'h03, 32'h03, 0, 1, 0, 5, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_mag_compare.md
# seq_mag_compare

Sequential, parametrised magnitude comparator. It walks two WIDTH-bit operands MSB-first, DIGIT bits per clock, and reports equal, greater or less with a start/done handshake. It supports a signed mode, optional early exit on the first differing digit, and cascade inputs so a lower-order comparison result can be chained in. It replaces wide flat comparator chains in datapaths where area matters more than single-cycle latency.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits compared per cycle; NDIG = WIDTH/DIGIT.
- EARLY_EXIT, 1, 1 = finish on the first unequal digit; 0 = always run NDIG cycles (constant time).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A, latched on accepted start.
- b  in  WIDTH  operand B, latched on accepted start.
- signed_mode  in  1  1 = two's-complement compare; latched on start.
- eq_in  in  1  cascade equal from lower-order stage; latched on start.
- gt_in  in  1  cascade greater from lower-order stage; latched on start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when results become valid.
- eq  out  1  A == B (cascade-qualified).
- gt  out  1  A > B.
- lt  out  1  A < B.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches a, b, signed_mode, eq_in and gt_in; digit index idx = NDIG-1; next state is RUN. start=0 stays in IDLE.
- Signed mode: invert bit WIDTH-1 of both latched operands (offset binary), then compare as unsigned.
- RUN: compare digit idx of A and B using digit_cmp.
  - If the digits are unequal, record the verdict (gt = A digit > B digit, lt = its inverse, eq = 0) in a sticky found flag. The first mismatch wins; later digits never override it.
  - If EARLY_EXIT=1 and a mismatch is found, or if idx == 0, go to DONE. Otherwise decrement idx and stay in RUN.
- All digits equal: eq = eq_in, gt = gt_in & ~eq_in, lt = ~eq_in & ~gt_in. eq_in has priority when eq_in and gt_in are both 1.
- DONE: drive the result registers and pulse done, then go to IDLE.
- Results hold their values until the next accepted start. At most one of eq, gt and lt is ever high.
- start while busy is ignored and not queued.

## Timing
- Reset values: state IDLE, busy=0, done=0, eq=0, gt=0, lt=0, idx=NDIG-1.
- Reset in any state has priority over every other event: the block returns to IDLE, the operation is abandoned and no done pulse is issued.
- Start is accepted at edge t. RUN covers edges t+1 through t+k, where k is the number of digits examined: k is 1..NDIG with EARLY_EXIT=1, and exactly NDIG with EARLY_EXIT=0.
- done is high, and eq/gt/lt are valid, in the cycle after edge t+k. Start-to-done latency is k+1 cycles; the worst case is NDIG+1.
- eq, gt and lt update on the same edge that raises done. They do not toggle during RUN.
- busy rises the cycle after the accepted start and falls the cycle after done.
- Back-to-back operation: the earliest next start is accepted in the first IDLE cycle after DONE.

## Structure
- Shared package cmp_pkg contains:
  - the state enum {IDLE, RUN, DONE};
  - a function ndig(WIDTH, DIGIT);
  - an index-width helper clog2(NDIG).
- Sub-module digit_cmp is purely combinational. It is parametrised by DIGIT, takes two DIGIT-bit inputs and outputs d_eq and d_gt. It is instantiated once and fed by a digit mux indexed by idx.
- Elaboration check: if WIDTH % DIGIT != 0, elaboration fails.

## Test plan
All scenarios use WIDTH=8 and DIGIT=2 (NDIG=4) unless stated otherwise.
- a=0, b=0, eq_in=1, gt_in=0, start -> eq=1, gt=0, lt=0; done 5 cycles after start; busy high for 5 cycles.
- a=0, b=128, EARLY_EXIT=1 -> lt=1; done 2 cycles after start (top digit differs).
- a=128, b=0, EARLY_EXIT=0 -> gt=1; done exactly 5 cycles after start. a=0x81, b=0x80 -> gt=1, also 5 cycles.
- a=0xFF, b=0x01: signed_mode=1 -> lt=1; signed_mode=0 -> gt=1. With signed_mode=1, a=0x80, b=0x7F -> lt=1.
- a=b=0x5A with cascade inputs:
  - eq_in=0, gt_in=1 -> gt=1;
  - eq_in=0, gt_in=0 -> lt=1;
  - eq_in=1, gt_in=1 -> eq=1, gt=0.
- Control scenarios:
  - start pulsed during RUN -> ignored; results reflect only the first operands.
  - rst asserted in the 2nd RUN cycle -> next cycle busy=0, done=0, eq=gt=lt=0, and no done pulse follows.
  - Repeat one scenario with WIDTH=32, DIGIT=4 and a=0xFFFF_FFFE, b=0xFFFF_FFFF, EARLY_EXIT=1 -> lt=1, done 9 cycles after start.
